// File: rtl/clk_div_by2.sv
// Registered integer clock divider: clk_out has a period of DIV_RATIO clk_in cycles.
// The high phase is floor(N/2) cycles and starts on the first edge after reset.
module clk_div_by2 #(
  parameter int DIV_RATIO = 2,
  localparam int CNT_W = (DIV_RATIO > 2) ? $clog2(DIV_RATIO) : 1
) (
  input  logic clk_in,
  input  logic rst,
  output logic clk_out
);

  if (DIV_RATIO < 2) begin : g_ratio_too_small
    $error("clk_div_by2: DIV_RATIO=%0d is illegal, DIV_RATIO must be >= 2", DIV_RATIO);
  end
  if (DIV_RATIO > 65536) begin : g_ratio_too_large
    $error("clk_div_by2: DIV_RATIO=%0d is illegal, DIV_RATIO must be <= 65536", DIV_RATIO);
  end

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV_RATIO - 1);
  localparam int               HALF    = DIV_RATIO / 2;

  // The initializers give the power-on state, so clk_out is 0 before any reset edge.
  logic [CNT_W-1:0] cnt = CNT_MAX;
  logic             q   = 1'b0;

  logic [CNT_W-1:0] cnt_next;
  logic             q_next;

  always_comb begin
    cnt_next = (cnt == CNT_MAX) ? '0 : cnt + CNT_W'(1);
    q_next   = (32'(cnt_next) < 32'(HALF));
  end

  always_ff @(posedge clk_in) begin
    if (!rst) begin
      cnt <= CNT_MAX;
      q   <= 1'b0;
    end else begin
      cnt <= cnt_next;
      q   <= q_next;
    end
  end

  assign clk_out = q;

endmodule

// File: tb/tb_clk_div_by2.sv
// Bench for clk_div_by2: N=2, N=3 and N=4 instances share clock and reset and
// are checked edge by edge against the k-based output formula.
module tb_clk_div_by2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic out2, out3, out4;

  int total = 0;
  int bad   = 0;

  // Expected {out4, out3, out2} after each edge, pushed when the edge's rst is driven.
  logic [2:0] exp_q[$];

  // Edges since the last reset edge for each instance (index 0:N=2, 1:N=3, 2:N=4).
  int k[3] = '{0, 0, 0};
  int n_of[3] = '{2, 3, 4};

  clk_div_by2 #(.DIV_RATIO(2)) dut2 (.clk_in(clk), .rst(rst), .clk_out(out2));
  clk_div_by2 #(.DIV_RATIO(3)) dut3 (.clk_in(clk), .rst(rst), .clk_out(out3));
  clk_div_by2 #(.DIV_RATIO(4)) dut4 (.clk_in(clk), .rst(rst), .clk_out(out4));

  // Clock: 20 ns period, first rising edge at 10 ns.
  initial forever #10 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: sim time expired, observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b required=%b at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Drive rst for the next rising edge, predict outputs, then compare 1 ns after it.
  task automatic step(input logic rst_val, input string tag);
    logic [2:0] e;
    logic [2:0] got;
    rst = rst_val;
    for (int i = 0; i < 3; i++) begin
      if (!rst_val) begin
        k[i] = 0;
        e[i] = 1'b0;
      end else begin
        k[i]++;
        e[i] = (((k[i] - 1) % n_of[i]) < (n_of[i] / 2));
      end
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    check(tag, {out4, out3, out2}, got);
  endtask

  initial begin
    // Reset pulse with no rising edge inside must leave power-on state intact.
    #2 rst = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("power_on", {out4, out3, out2}, 3'b000);
    #4;
    check("before_first_edge", {out4, out3, out2}, 3'b000);

    // Free run from power-on: 20 edges (N=2 rises at 10 ns, falls at 30 ns, ...).
    for (int i = 0; i < 20; i++) step(1'b1, "run_from_power_on");

    // rst held low across three edges, then released.
    for (int i = 0; i < 3; i++) step(1'b0, "reset_held");
    step(1'b1, "release_first");
    step(1'b1, "release_second");

    // One-edge reset pulse while N=2 output is high.
    step(1'b1, "pre_pulse_high");
    check("pre_pulse_out2_is_1", {2'b00, out2}, 3'b001);
    step(1'b0, "pulse_while_high");
    step(1'b1, "restart_after_pulse");
    check("restart_out2_is_1", {2'b00, out2}, 3'b001);

    // Long run across several counter wraps for N=3 and N=4.
    for (int i = 0; i < 12; i++) step(1'b1, "wrap_run");

    // Random reset pulses at random phases.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) step(1'b0, "random_reset");
      else step(1'b1, "random_run");
    end

    total++;
    assert (exp_q.size() == 0) else begin
      bad++;
      $error("FAIL queue_drain: observed=%0d required=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clk_div_by2.md
Name: clk_div_by2

Overview:
- Registered integer clock divider. Default configuration divides the input clock by 2 with 50% duty cycle.
- Sits at the clock-generation level. It derives a slow fabric/peripheral clock from a single reference clock.
- Output is driven directly from a flip-flop, so it is glitch-free. No combinational path runs from clk_in to clk_out.

Parameters:
- DIV_RATIO, 2, integer division factor N; legal range 2..65536. Values below 2 must raise an elaboration-time error.
- CNT_W, $clog2(DIV_RATIO) (minimum 1), width of the internal phase counter; derived, not to be overridden.

Ports:
- clk_in  input  1  reference clock; all logic on its rising edge.
- rst     input  1  synchronous, active-low reset (0 = reset), sampled on rising clk_in.
- clk_out output 1  divided clock, registered.

Behaviour:
- Single clock domain (clk_in). No negedge logic, no latches, no gated clocks.
- Internal state:
  - phase counter cnt[CNT_W-1:0];
  - output register q, which drives clk_out.
- Power-on/initial value: cnt = N-1, q = 0.
  - Defined via register initial value, so clk_out is never X in simulation.
  - This also holds when no rising edge occurs while rst is low.
- Reset: on a rising edge of clk_in with rst == 0, set cnt <= N-1 and q <= 0.
  - clk_out is 0 in the cycle after the reset edge.
  - A low rst pulse that contains no rising edge has no effect.
- Run, on a rising edge with rst == 1:
  - cnt_next = (cnt == N-1) ? 0 : cnt + 1; cnt <= cnt_next.
  - q <= (cnt_next < H), where H = floor(N/2).
- Resulting output:
  - Let k be the number of rising edges after the last reset edge (k starts at 1).
  - clk_out after edge k is 1 iff ((k-1) mod N) < H.
  - First high level appears after the first run edge (latency 1 clk_in cycle).
- Even N: high N/2 cycles, low N/2 cycles, 50% duty. N=2 means clk_out toggles on every rising clk_in edge.
- Odd N: high floor(N/2) cycles, low ceil(N/2) cycles. Duty is not 50%, by design.
- Period of clk_out = N clk_in periods, exactly, with no drift.
- Wrap-around: cnt wraps N-1 -> 0 with no skipped or repeated phase.
- Reset mid-operation: takes effect on the same edge regardless of phase.
  - clk_out goes low, or stays low.
  - The high phase restarts on the first edge after rst returns to 1.
- Reset held low: clk_out held at 0 indefinitely, cnt held at N-1.
- Counter arithmetic is unsigned, CNT_W bits. cnt never exceeds N-1.

Test Plan:
- N=2, 50 MHz clk_in (20 ns period, first rise at t=10 ns); rst pulsed low t=2..4 ns with no edge inside, then rst=1.
  - clk_out must be 0 from t=0, never X.
  - clk_out rises at 10 ns and falls at 30 ns, then toggles every 20 ns (40 ns period) for 20 clk_in cycles.
- N=2, rst held low across 3 rising edges, then released.
  - clk_out must be 0 throughout reset.
  - clk_out must be 1 after the first edge with rst=1 and 0 after the second.
- N=2, rst pulsed low for one edge while clk_out=1.
  - clk_out must be 0 after that edge.
  - It must restart at 1 on the next edge with rst=1.
- N=4: clk_out pattern per edge after reset must be 1,1,0,0,1,1,0,0; period 4 clk_in cycles, 50% duty.
- N=3: clk_out pattern must be 1,0,0,1,0,0; check 12 edges for exact period and no drift across counter wrap.
- N=1 elaboration must fail with an error message naming DIV_RATIO.
